uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter: configurable data bits, parity and stop bits,
//  with an optional transmit FIFO. Drop-in successor to the fixed 8N1 transmitter
//  on the SoC peripheral bus side. Accepts bytes over a valid/ready handshake and
//  serialises them LSB-first onto o_uart_tx at BAUD_RATE.
// PARAMETERS
//  CLK_FREQ_HZ  0       input clock frequency in Hz; must be set by the instantiator
//  BAUD_RATE    57600   line rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer division), DIV >= 2
//  DATA_BITS    8       data bits per frame, 5..9
//  PARITY       0       0 = none, 1 = odd, 2 = even
//  STOP_BITS    1       1 or 2
//  FIFO_DEPTH   16      FIFO entries, power of two >= 2 (used only with UART_TX_FIFO_EN)
// PORTS
//  i_clk         in   1          clock
//  i_rst_n       in   1          asynchronous active-low reset
//  i_data        in   DATA_BITS  word to send; sampled on accept
//  i_valid       in   1          i_data valid
//  o_ready       out  1          transmitter can accept; accept = i_valid & o_ready
//  o_busy        out  1          frame on the line or word pending
//  o_level       out  $clog2(FIFO_DEPTH)+1  FIFO occupancy (0 without UART_TX_FIFO_EN)
//  o_uart_tx     out  1          serial line, idles high
// BEHAVIOUR
//  - Reset (async, on i_rst_n low): o_uart_tx=1, o_ready=1, o_busy=0, o_level=0, FSM=IDLE,
//    FIFO emptied, baud counter cleared. Reset mid-frame drives the line high immediately.
//    The pending word is discarded and is never resent.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START if a word is pending.
//  - Each bit is held exactly DIV cycles. The baud counter is reloaded with DIV-1 at each
//    bit start; the bit ends when the counter reaches 0.
//  - START: line 0. DATA: bit i = word[i], i = 0..DATA_BITS-1.
//  - PARITY: odd -> ~^word, even -> ^word; state skipped when PARITY=0.
//  - STOP: line 1 for STOP_BITS*DIV cycles.
//  - Back-to-back: if a word is pending when STOP ends, START begins the next cycle.
//    There is no idle gap between frames.
//  - o_busy = (FSM != IDLE) | word pending.
//  - Illegal parameters (DIV<2, DATA_BITS out of range, PARITY>2, STOP_BITS not 1/2):
//    $error at elaboration.
// CONFIGURATION
//  UART_TX_FIFO_EN defined:
//  - FIFO of FIFO_DEPTH words; o_ready = (level != FIFO_DEPTH), from registered state.
//  - Push on accept. Pop when FSM is IDLE, or on the last STOP cycle, and level != 0.
//  - Push and pop in the same cycle leave level unchanged.
//  - Push while full is impossible, because o_ready=0.
//  - Latency: accept at cycle N into an empty FIFO with FSM IDLE -> pop at N+1, start bit at N+2.
//  UART_TX_FIFO_EN undefined:
//  - Single holding register; o_level tied to 0.
//  - o_ready=1 only when the holding register is empty.
//  - The holding register loads at cycle N and frees when the word moves to the shifter;
//    o_ready returns to 1 at N+2 in IDLE.
//  - Latency: accept at cycle N with FSM IDLE -> start bit at N+1. A word accepted during a
//    frame waits in the holding register.
// TESTING
//  Common setup: CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000, so DIV=10.
//  1. 8N1, send 0xA5 -> line 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each,
//     then 1 for 10 cycles; o_busy falls after the stop bit.
//  2. 8E2, send 0xA5 -> parity bit 0 and 20 stop cycles; 8O1, send 0xA5 -> parity bit 1.
//  3. 7N1, send 0x7F then 0x00 back-to-back -> exactly 90 cycles per frame, with the second
//     start bit immediately after the first stop bit.
//  4. FIFO_EN with FIFO_DEPTH=4: push 5 words with the line stalled -> o_ready=0 once level=4;
//     all frames are then sent in order with no gaps.
//  5. Assert i_rst_n low mid-DATA of 0x00 -> o_uart_tx=1 in the same cycle, o_level=0;
//     after release the line stays idle.
//  6. Hold i_valid=1 continuously with random data -> every accepted word appears exactly once,
//     in order, and no word is accepted while o_ready=0.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (data bits, parity, stop bits)
// Optional transmit FIFO enabled by defining UART_TX_FIFO_EN; default is a single holding register.
module uart_tx_cfg #(
  parameter int CLK_FREQ_HZ = 0,
  parameter int BAUD_RATE   = 57600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DATA_BITS-1:0]        i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_uart_tx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;

  generate
    if (DIV < 2) begin : g_err_div
      $error("uart_tx_cfg: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;

  logic                 w_accept;
  logic                 w_start;
  logic                 w_last_stop;
  logic                 w_par;
  logic [DATA_BITS-1:0] w_word;

  assign w_accept    = i_valid & o_ready;
  assign w_last_stop = (r_state == S_STOP) && (r_cnt == '0) && (r_idx == 4'(STOP_BITS - 1));
  assign w_par       = (PARITY == 1) ? ~^w_word : ^w_word;
  assign o_uart_tx   = r_tx;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [LW-1:0]        r_level;

  assign o_ready = (r_level != LW'(FIFO_DEPTH));
  assign o_level = r_level;
  assign o_busy  = (r_state != S_IDLE) || (r_level != '0);
  assign w_start = (r_level != '0) && ((r_state == S_IDLE) || w_last_stop);
  assign w_word  = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_accept) r_wr <= r_wr + AW'(1);
      if (w_start)  r_rd <= r_rd + AW'(1);
      case ({w_accept, w_start})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
`else
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_v;
  logic                 r_hold_used;
  logic                 w_pending;
  logic                 w_direct;

  // A word accepted while idle goes straight to the shifter; the holding
  // register still reads occupied for one cycle and is then released.
  assign w_pending = r_hold_v & ~r_hold_used;
  assign w_direct  = w_accept && (r_state == S_IDLE);
  assign w_start   = w_direct || (w_pending && ((r_state == S_IDLE) || w_last_stop));
  assign w_word    = w_direct ? i_data : r_hold;
  assign o_ready   = ~r_hold_v;
  assign o_level   = '0;
  assign o_busy    = (r_state != S_IDLE) || w_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_hold_used <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= i_data;
      r_hold_v    <= 1'b1;
      r_hold_used <= w_direct;
    end else if (r_hold_used || (w_pending && w_start)) begin
      r_hold_v    <= 1'b0;
      r_hold_used <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_cnt   <= CW'(DIV - 1);
            r_shift <= w_word;
            r_par   <= w_par;
          end
        end
        default: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_cnt <= CW'(DIV - 1);
            case (r_state)
              S_START: begin
                r_state <= S_DATA;
                r_tx    <= r_shift[0];
                r_idx   <= '0;
              end
              S_DATA: begin
                if (r_idx == 4'(DATA_BITS - 1)) begin
                  r_idx <= '0;
                  if (PARITY != 0) begin
                    r_state <= S_PARITY;
                    r_tx    <= r_par;
                  end else begin
                    r_state <= S_STOP;
                    r_tx    <= 1'b1;
                  end
                end else begin
                  r_idx   <= r_idx + 4'd1;
                  r_shift <= r_shift >> 1;
                  r_tx    <= r_shift[1];
                end
              end
              S_PARITY: begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
              S_STOP: begin
                if (r_idx == 4'(STOP_BITS - 1)) begin
                  r_idx <= '0;
                  if (w_start) begin
                    r_state <= S_START;
                    r_tx    <= 1'b0;
                    r_shift <= w_word;
                    r_par   <= w_par;
                  end else begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                  end
                end else begin
                  r_idx <= r_idx + 4'd1;
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_tx    <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg (8N1, 8E2, 8O1, 7N1 instances)
// Expected line waveforms are built from frame rules; FIFO scenario compiles when UART_TX_FIFO_EN is defined.
module tb_uart_tx_cfg;
  localparam int CLK  = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int DIV  = 10;
  localparam int FD   = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       ready [4];
  logic       busy  [4];
  logic       tx    [4];
  logic [2:0] level [4];

  int db_a  [4] = '{8, 8, 8, 7};
  int par_a [4] = '{0, 2, 1, 0};
  int sb_a  [4] = '{1, 2, 1, 1};

  int checks = 0;
  int failures = 0;
  logic [7:0] words[$];
  bit         exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ_HZ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)) u_8n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_busy(busy[0]), .o_level(level[0]), .o_uart_tx(tx[0]));
  uart_tx_cfg #(.CLK_FREQ_HZ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(FD)) u_8e2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_busy(busy[1]), .o_level(level[1]), .o_uart_tx(tx[1]));
  uart_tx_cfg #(.CLK_FREQ_HZ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(FD)) u_8o1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[2]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_busy(busy[2]), .o_level(level[2]), .o_uart_tx(tx[2]));
  uart_tx_cfg #(.CLK_FREQ_HZ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)) u_7n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[3][6:0]), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_busy(busy[3]), .o_level(level[3]), .o_uart_tx(tx[3]));

  function automatic void push_frame(input int idx, input logic [7:0] w);
    int ones;
    bit pbit;
    ones = 0;
    for (int i = 0; i < db_a[idx]; i++) ones += int'(w[i]);
    repeat (DIV) exp_q.push_back(1'b0);
    for (int i = 0; i < db_a[idx]; i++) repeat (DIV) exp_q.push_back(w[i]);
    if (par_a[idx] != 0) begin
      pbit = (par_a[idx] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      repeat (DIV) exp_q.push_back(pbit);
    end
    repeat (sb_a[idx] * DIV) exp_q.push_back(1'b1);
  endfunction

  task automatic run_stream(input int idx, input string name, input bit expect_full);
    int k, cyc, delay, bad, pos, first_pos, lvl_bad;
    bit fe, fexp, fact, saw_full;
    exp_q.delete();
    foreach (words[i]) push_frame(idx, words[i]);
    k = 0; cyc = 0; delay = -1; bad = 0; pos = 0; first_pos = -1; lvl_bad = 0;
    fexp = 1'b0; fact = 1'b0; saw_full = 1'b0;
    while (exp_q.size() != 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (delay == 0) begin
        fe = exp_q.pop_front();
        if (tx[idx] !== fe || busy[idx] !== 1'b1) begin
          if (bad == 0) begin first_pos = pos; fexp = fe; fact = tx[idx]; end
          bad++;
        end
        pos++;
      end else if (delay > 0) begin
        delay--;
      end
`ifdef UART_TX_FIFO_EN
      if (ready[idx] !== (level[idx] != 3'd4)) lvl_bad++;
      if (level[idx] == 3'd4) saw_full = 1'b1;
`else
      if (level[idx] !== 3'd0) lvl_bad++;
`endif
      valid[idx] = (k < words.size());
      if (valid[idx]) data[idx] = words[k];
      if (valid[idx] && ready[idx] === 1'b1) begin
        k++;
        if (delay < 0) delay = LAT - 1;
      end
    end
    valid[idx] = 1'b0;
    checks++;
    if (k != words.size()) begin
      failures++; $display("FAIL %s accepted: got %0d words, expected %0d", name, k, words.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL %s timeout: %0d line cycles unchecked, expected 0", name, exp_q.size());
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s line: %0d bad cycles, first at %0d tx=%0b expected %0b (busy must be 1)", name, bad, first_pos, fact, fexp);
    end
    checks++;
    if (lvl_bad != 0) begin
      failures++; $display("FAIL %s level/ready: %0d inconsistent cycles, expected 0", name, lvl_bad);
    end
    if (expect_full) begin
      checks++;
      if (!saw_full) begin
        failures++; $display("FAIL %s full: level never reached %0d", name, FD);
      end
    end
    @(negedge clk);
    checks++;
    if (tx[idx] !== 1'b1 || busy[idx] !== 1'b0) begin
      failures++; $display("FAIL %s idle_after: tx=%0b busy=%0b expected tx=1 busy=0", name, tx[idx], busy[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx[i] !== 1'b1 || ready[i] !== 1'b1 || busy[i] !== 1'b0 || level[i] !== 3'd0) begin
        failures++;
        $display("FAIL reset_state[%0d]: tx=%0b ready=%0b busy=%0b level=%0d expected 1 1 0 0", i, tx[i], ready[i], busy[i], level[i]);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_handshake();
    int cnt;
    @(negedge clk);
    valid[0] = 1'b1; data[0] = 8'h3C;
    checks++;
    if (ready[0] !== 1'b1) begin failures++; $display("FAIL hs_ready_n: ready=%0b expected 1", ready[0]); end
    @(negedge clk);
    valid[0] = 1'b0;
    checks++;
    if (tx[0] !== (LAT == 1 ? 1'b0 : 1'b1) || ready[0] !== (LAT == 1 ? 1'b0 : 1'b1)) begin
      failures++;
      $display("FAIL hs_n1: tx=%0b ready=%0b expected tx=%0b ready=%0b", tx[0], ready[0], LAT == 1 ? 1'b0 : 1'b1, LAT == 1 ? 1'b0 : 1'b1);
    end
    cnt = 0;
    for (int i = 0; i < 300 && busy[0] === 1'b1; i++) begin
      if (i == 1) begin
        checks++;
        if (tx[0] !== 1'b0 || ready[0] !== 1'b1) begin
          failures++; $display("FAIL hs_n2: tx=%0b ready=%0b expected tx=0 ready=1", tx[0], ready[0]);
        end
      end
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 100 + LAT - 1) begin
      failures++; $display("FAIL hs_busy_len: busy for %0d cycles, expected %0d", cnt, 100 + LAT - 1);
    end
  endtask

  task automatic test_8n1();
    words = '{8'hA5};
    run_stream(0, "8n1_a5", 1'b0);
  endtask

  task automatic test_parity();
    words = '{8'hA5};
    run_stream(1, "8e2_a5", 1'b0);
    words = '{8'hA5};
    run_stream(2, "8o1_a5", 1'b0);
  endtask

  task automatic test_back_to_back();
    words = '{8'h7F, 8'h00};
    run_stream(3, "7n1_b2b", 1'b0);
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo();
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_stream(0, "fifo_5", 1'b1);
  endtask
`endif

  task automatic test_random();
    words.delete();
    repeat (6) words.push_back(8'($urandom));
    run_stream(0, "rand_8n1", 1'b0);
    words.delete();
    repeat (4) words.push_back(8'($urandom));
    run_stream(2, "rand_8o1", 1'b0);
    words.delete();
    repeat (5) words.push_back(8'($urandom_range(0, 127)));
    run_stream(3, "rand_7n1", 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    valid[0] = 1'b1; data[0] = 8'h00;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (24) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: tx=%0b busy=%0b expected tx=0 busy=1", tx[0], busy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || level[0] !== 3'd0 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_async: tx=%0b level=%0d busy=%0b ready=%0b expected 1 0 0 1", tx[0], level[0], busy[0], ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL rst_mid_after: %0d non-idle cycles, expected 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    test_reset();
    test_handshake();
    test_8n1();
    test_parity();
    test_back_to_back();
`ifdef UART_TX_FIFO_EN
    test_fifo();
`endif
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
